axi_r_mux_s2m: RTL

Read-data return path of the AXI interconnect: merges the R channels of four slaves onto one master R port. Drives the request vector of the 4-way round-robin slave-to-master arbiter and consumes its one-hot select. Locks the grant for a whole burst until the RLAST beat is accepted. Registers the master-side outputs through a 2-entry skid buffer.

---
 rtl/axi_ic_pkg.sv | 19 +
 rtl/axi_r_mux_s2m_if.sv | 45 ++++
 rtl/axi_r_skid2.sv | 65 ++++++
 rtl/axi_r_mux_s2m.sv | 113 +++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect blocks: slave count, response
// width, the burst-lock FSM encoding and a one-hot AND-OR select helper.
package axi_ic_pkg;

  localparam int unsigned NUM_S  = 4;
  localparam int unsigned RESP_W = 2;

  typedef enum logic {
    IDLE,
    LOCK
  } fsm_state_e;

  // One bit of a one-hot AND-OR mux; an all-zero select yields 0.
  function automatic logic onehot_mux_bit(input logic [NUM_S-1:0] sel,
                                          input logic [NUM_S-1:0] bits);
    return |(sel & bits);
  endfunction

endpackage

// File: rtl/axi_r_mux_s2m_if.sv
// R-channel bundle for the slave-to-master read mux: four slave R ports,
// the arbiter request/grant pair and the single master R port.
interface axi_r_mux_s2m_if
  import axi_ic_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) ();

  logic [NUM_S-1:0]        s_rvalid;
  logic [NUM_S-1:0]        s_rready;
  logic [NUM_S*DATA_W-1:0] s_rdata;
  logic [NUM_S*RESP_W-1:0] s_rresp;
  logic [NUM_S-1:0]        s_rlast;
  logic [NUM_S*ID_W-1:0]   s_rid;

  logic [NUM_S-1:0]        arb_req;
  logic [NUM_S-1:0]        arb_sel;

  logic                    m_rvalid;
  logic                    m_rready;
  logic [DATA_W-1:0]       m_rdata;
  logic [RESP_W-1:0]       m_rresp;
  logic                    m_rlast;
  logic [ID_W-1:0]         m_rid;

  modport slave (
    input  s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    input  arb_sel,
    input  m_rready,
    output s_rready,
    output arb_req,
    output m_rvalid, m_rdata, m_rresp, m_rlast, m_rid
  );

  modport master (
    output s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    output arb_sel,
    output m_rready,
    input  s_rready,
    input  arb_req,
    input  m_rvalid, m_rdata, m_rresp, m_rlast, m_rid
  );

endinterface

// File: rtl/axi_r_skid2.sv
// Two-entry FIFO-ordered skid buffer; the head register drives the output
// directly so the consumer sees registered payload and valid.
module axi_r_skid2 #(
  parameter int unsigned W = 39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         room_o,
  input  logic         rdy_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop;

  assign valid_o = (count_q != 2'd0);
  assign room_o  = (count_q < 2'd2);
  assign dout_o  = head_q;
  assign pop     = valid_o & rdy_i;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({push_i, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = din_i;
        else                 tail_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Simultaneous push/pop: the new beat lands behind whatever remains.
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/axi_r_mux_s2m.sv
// Read-data return mux: four slave R channels onto one master R port, with
// the arbiter grant held for a whole burst and a skid-buffered master side.
module axi_r_mux_s2m
  import axi_ic_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input logic             clk,
  input logic             rst_n,
  axi_r_mux_s2m_if.slave  bus
);

  localparam int unsigned PL_W = DATA_W + RESP_W + 1 + ID_W;

  fsm_state_e       state_q;
  logic [NUM_S-1:0] lock_sel_q;

  logic             room;
  logic [NUM_S-1:0] arb_req_c;
  logic [NUM_S-1:0] rready_c;
  logic [NUM_S-1:0] acc;
  logic             push;
  logic             push_last;
  logic [PL_W-1:0]  push_pl;
  logic [PL_W-1:0]  head_pl;
  logic [PL_W-1:0]  slv_pl [NUM_S];
  logic [NUM_S-1:0] col    [PL_W];

  // Requests are withheld whenever a beat cannot be taken so the arbiter's
  // rotation only reflects grants that really transfer data.
  always_comb begin
    arb_req_c = '0;
    rready_c  = '0;
    if (rst_n && room) begin
      unique case (state_q)
        IDLE: begin
          arb_req_c = bus.s_rvalid;
          rready_c  = bus.arb_sel;
        end
        LOCK:    rready_c = lock_sel_q;
        default: ;
      endcase
    end
  end

  assign bus.arb_req  = arb_req_c;
  assign bus.s_rready = rready_c;

  assign acc  = bus.s_rvalid & rready_c;
  assign push = |acc;

  always_comb begin
    for (int unsigned s = 0; s < NUM_S; s++) begin
      slv_pl[s] = {bus.s_rdata[s*DATA_W +: DATA_W],
                   bus.s_rresp[s*RESP_W +: RESP_W],
                   bus.s_rlast[s],
                   bus.s_rid[s*ID_W +: ID_W]};
    end
  end

  always_comb begin
    push_pl = '0;
    for (int unsigned b = 0; b < PL_W; b++) begin
      col[b] = '0;
      for (int unsigned s = 0; s < NUM_S; s++) col[b][s] = slv_pl[s][b];
      push_pl[b] = onehot_mux_bit(acc, col[b]);
    end
  end

  assign push_last = push_pl[ID_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (push && !push_last) begin
            lock_sel_q <= acc;
            state_q    <= LOCK;
          end
        end
        LOCK: begin
          if (push && push_last) begin
            lock_sel_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axi_r_skid2 #(
    .W(PL_W)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .din_i  (push_pl),
    .room_o (room),
    .rdy_i  (bus.m_rready),
    .valid_o(bus.m_rvalid),
    .dout_o (head_pl)
  );

  assign {bus.m_rdata, bus.m_rresp, bus.m_rlast, bus.m_rid} = head_pl;

  a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.arb_sel));

endmodule
